backup_row_packer: RTL

// - Parametrised successor to the input-backup path.
// - Per command, pops one input-memory row from the input FIFO and applies left and right zero padding.
// - Drives the array portion onto a stride-scaled computing-group bus with valid/ready handshake.
// - Stores the overflow tail into a per-kernel-row shift backup bank for later shift-in.
// - Sits between the input FIFO and the compute array feeder.

---
 rtl/backup_row_packer_pkg.sv | 42 ++++
 rtl/backup_row_packer_row_pad_splitter.sv | 31 +++
 rtl/backup_row_packer.sv | 94 +++++++++
 3 files changed

// File: rtl/backup_row_packer_pkg.sv
// Shared types and width constants for the input-backup row packer.
package backup_row_packer_pkg;
  localparam int GROUP   = 16;
  localparam int MEM_W   = 32;
  localparam int MAX_K   = 7;
  localparam int SHIFT   = 16;
  localparam int FW      = 8;
  localparam int MAX_STR = 2;

  localparam int PACK_LANES   = GROUP * MAX_STR;
  localparam int PACK_ROW_W   = $clog2(MAX_K);
  localparam int PACK_WID_W   = $clog2(MEM_W + 1);
  localparam int PACK_PAD_W   = $clog2(GROUP + 1);
  localparam int PACK_STR_W   = $clog2(MAX_STR + 1);
  localparam int PACK_ARITH_W = $clog2(MEM_W + 2 * GROUP + 1);
  localparam int PACK_IDX_W   = $clog2(MEM_W);

  typedef logic signed [FW-1:0] feature_t;
  typedef logic [MEM_W-1:0][FW-1:0] mem_row_t;
  typedef logic [PACK_LANES-1:0][FW-1:0] lanes_t;
  typedef logic [SHIFT-1:0][FW-1:0] backup_row_t;
  typedef logic [MAX_K-1:0][SHIFT-1:0][FW-1:0] backup_bank_t;

  typedef struct packed {
    logic [PACK_ROW_W-1:0] row;
    logic [PACK_WID_W-1:0] width;
    logic [PACK_PAD_W-1:0] lpad;
    logic [PACK_PAD_W-1:0] rpad;
    logic [PACK_STR_W-1:0] stride;
  } backup_cmd_t;

  // Padded-row element at position p: FIFO data inside the window, zero elsewhere.
  function automatic feature_t pick(input mem_row_t row, input logic [PACK_ARITH_W-1:0] p,
                                    input logic [PACK_ARITH_W-1:0] lpad,
                                    input logic [PACK_ARITH_W-1:0] width);
    logic [PACK_ARITH_W-1:0] off;
    off = p - lpad;
    if (p >= lpad && p < lpad + width && off < PACK_ARITH_W'(MEM_W))
      return feature_t'(row[off[PACK_IDX_W-1:0]]);
    return '0;
  endfunction
endpackage

// File: rtl/backup_row_packer_row_pad_splitter.sv
// Splits one padded FIFO row into the array lanes and the shift-backup tail.
import backup_row_packer_pkg::*;

module row_pad_splitter (
  input  mem_row_t    row,
  input  backup_cmd_t cmd,
  output lanes_t      lanes,
  output backup_row_t tail,
  output logic        ovf
);
  logic [PACK_ARITH_W-1:0] stride_eff, a_len, t_len, lpad, width;
  logic unused_row;

  assign unused_row = ^cmd.row;
  // Out-of-range strides fall back to 1.
  assign stride_eff = (cmd.stride == '0 || cmd.stride > PACK_STR_W'(MAX_STR))
                      ? PACK_ARITH_W'(1) : PACK_ARITH_W'(cmd.stride);
  assign a_len = PACK_ARITH_W'(GROUP) * stride_eff;
  assign lpad  = PACK_ARITH_W'(cmd.lpad);
  assign width = PACK_ARITH_W'(cmd.width);
  assign t_len = lpad + width + PACK_ARITH_W'(cmd.rpad);
  assign ovf   = t_len > a_len + PACK_ARITH_W'(SHIFT);

  for (genvar p = 0; p < PACK_LANES; p++) begin : g_lane
    assign lanes[p] = (PACK_ARITH_W'(p) < a_len) ? pick(row, PACK_ARITH_W'(p), lpad, width) : '0;
  end

  for (genvar i = 0; i < SHIFT; i++) begin : g_tail
    assign tail[i] = pick(row, a_len + PACK_ARITH_W'(i), lpad, width);
  end
endmodule

// File: rtl/backup_row_packer.sv
// Command FSM, output register and per-kernel-row shift backup bank.
import backup_row_packer_pkg::*;

module backup_row_packer (
  input  logic                          clock,
  input  logic                          resetN,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [PACK_ROW_W-1:0]         cmd_row,
  input  logic [PACK_WID_W-1:0]         cmd_width,
  input  logic [PACK_PAD_W-1:0]         cmd_lpad,
  input  logic [PACK_PAD_W-1:0]         cmd_rpad,
  input  logic [PACK_STR_W-1:0]         cmd_stride,
  input  logic [MEM_W*FW-1:0]           fifo_data,
  input  logic                          fifo_empty,
  output logic                          fifo_rd_en,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [PACK_LANES*FW-1:0]      out_bus,
  output logic [PACK_ROW_W-1:0]         out_row,
  output logic [MAX_K*SHIFT*FW-1:0]     shift_backup,
  output logic                          ovf_err
);
  typedef enum logic [1:0] {IDLE, FETCH, OUT} state_t;

  state_t       state, state_nxt;
  backup_cmd_t  cmd_q;
  lanes_t       lanes, bus_q;
  backup_row_t  tail;
  backup_bank_t bank;
  logic         ovf, pop;

  row_pad_splitter u_split (
    .row   (mem_row_t'(fifo_data)),
    .cmd   (cmd_q),
    .lanes (lanes),
    .tail  (tail),
    .ovf   (ovf)
  );

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    out_valid = 1'b0;
    pop       = 1'b0;
    unique case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = FETCH;
      end
      FETCH: begin
        pop = ~fifo_empty;
        if (pop) state_nxt = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Gate with reset so an aborted FETCH cannot pop during the reset cycle.
  assign fifo_rd_en = pop & resetN;

  always_ff @(posedge clock) begin
    if (!resetN) state <= IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge clock) begin
    if (!resetN) begin
      cmd_q   <= '0;
      bus_q   <= '0;
      out_row <= '0;
      bank    <= '0;
      ovf_err <= 1'b0;
    end else begin
      if (state == IDLE && cmd_valid)
        cmd_q <= '{row: cmd_row, width: cmd_width, lpad: cmd_lpad,
                   rpad: cmd_rpad, stride: cmd_stride};
      if (pop) begin
        bus_q   <= lanes;
        out_row <= cmd_q.row;
        for (int r = 0; r < MAX_K; r++)
          if (cmd_q.row == PACK_ROW_W'(r)) bank[r] <= tail;
        if (ovf) ovf_err <= 1'b1;
      end
    end
  end

  assign out_bus      = bus_q;
  assign shift_backup = bank;
endmodule
